regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: integer results own the write port, FP results queue in a 2-entry FIFO.
// Optional per-register pending-FP-write tracking on `busy` is enabled by defining WB_BUSY_TRACK_EN.
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        int_we,
    input  logic [4:0]  int_rd,
    input  logic [31:0] int_result,
    input  logic        fp_valid,
    output logic        fp_ready,
    input  logic [4:0]  fp_rd,
    input  logic [31:0] fp_result,
    input  logic        issue_fp,
    input  logic [4:0]  issue_rd,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic [31:0] busy,
    output logic [1:0]  fifo_cnt
);

    logic [1:0][4:0]  rd_q, rd_d;
    logic [1:0][31:0] dat_q, dat_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             we3_q, we3_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;

    logic             int_sel_s, accept_s, keep_s, pop_s, bypass_s, push_s;
    logic             fp_load_s;
    logic [4:0]       fp_load_rd_s;
    logic [1:0]       wr_idx_s;

    // Ready depends on occupancy alone so the FP unit never sees integer traffic.
    assign fp_ready  = (cnt_q < 2'd2);
    assign int_sel_s = int_we && (int_rd != 5'd0);
    assign accept_s  = fp_valid && fp_ready;
    assign keep_s    = accept_s && (fp_rd != 5'd0);
    assign pop_s     = !int_sel_s && (cnt_q != 2'd0);
    assign bypass_s  = !int_sel_s && (cnt_q == 2'd0) && keep_s;
    assign push_s    = keep_s && !bypass_s;
    assign wr_idx_s  = pop_s ? (cnt_q - 2'd1) : cnt_q;

    // Port selection and FIFO next state.
    always_comb begin
        rd_d         = rd_q;
        dat_d        = dat_q;
        cnt_d        = cnt_q;
        we3_d        = 1'b0;
        a3_d         = a3_q;
        wd3_d        = wd3_q;
        fp_load_s    = 1'b0;
        fp_load_rd_s = 5'd0;

        if (int_sel_s) begin
            we3_d = 1'b1;
            a3_d  = int_rd;
            wd3_d = int_result;
        end else if (pop_s) begin
            we3_d        = 1'b1;
            a3_d         = rd_q[0];
            wd3_d        = dat_q[0];
            fp_load_s    = 1'b1;
            fp_load_rd_s = rd_q[0];
        end else if (bypass_s) begin
            we3_d        = 1'b1;
            a3_d         = fp_rd;
            wd3_d        = fp_result;
            fp_load_s    = 1'b1;
            fp_load_rd_s = fp_rd;
        end else begin
            we3_d = 1'b0;
        end

        if (pop_s) begin
            rd_d[0]  = rd_q[1];
            dat_d[0] = dat_q[1];
        end else begin
            rd_d[0]  = rd_d[0];
        end

        // Push lands behind whatever survives this cycle's pop, keeping order.
        if (push_s) begin
            rd_d[wr_idx_s[0]]  = fp_rd;
            dat_d[wr_idx_s[0]] = fp_result;
        end else begin
            rd_d[1] = rd_d[1];
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Output port and FIFO state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            dat_q <= '0;
            cnt_q <= 2'd0;
            we3_q <= 1'b0;
            a3_q  <= 5'd0;
            wd3_q <= 32'd0;
        end else begin
            rd_q  <= rd_d;
            dat_q <= dat_d;
            cnt_q <= cnt_d;
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign we3      = we3_q;
    assign a3       = a3_q;
    assign wd3      = wd3_q;
    assign fifo_cnt = cnt_q;

`ifdef WB_BUSY_TRACK_EN
    logic [31:0] busy_q, busy_d, busy_set_s, busy_clr_s;

    // A new issue to the same register outranks the retiring write.
    always_comb begin
        busy_set_s = 32'd0;
        busy_clr_s = 32'd0;
        if (issue_fp && (issue_rd != 5'd0)) begin
            busy_set_s[issue_rd] = 1'b1;
        end else begin
            busy_set_s = 32'd0;
        end
        if (fp_load_s) begin
            busy_clr_s[fp_load_rd_s] = 1'b1;
        end else begin
            busy_clr_s = 32'd0;
        end
        busy_d    = (busy_q & ~busy_clr_s) | busy_set_s;
        busy_d[0] = 1'b0;
    end

    // Pending-write mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;
`else
    logic busy_unused_s;
    assign busy_unused_s = ^{issue_fp, issue_rd, fp_load_s, fp_load_rd_s};
    assign busy          = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected port writes are queued as stimulus is driven
// and popped whenever the DUT raises we3.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        int_we;
    logic [4:0]  int_rd;
    logic [31:0] int_result;
    logic        fp_valid;
    logic        fp_ready;
    logic [4:0]  fp_rd;
    logic [31:0] fp_result;
    logic        issue_fp;
    logic [4:0]  issue_rd;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [31:0] busy;
    logic [1:0]  fifo_cnt;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

`ifdef WB_BUSY_TRACK_EN
    localparam logic [31:0] BUSY12 = 32'h0000_1000;
`else
    localparam logic [31:0] BUSY12 = 32'h0000_0000;
`endif

    regfile_wb_arbiter dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .int_we     (int_we),
        .int_rd     (int_rd),
        .int_result (int_result),
        .fp_valid   (fp_valid),
        .fp_ready   (fp_ready),
        .fp_rd      (fp_rd),
        .fp_result  (fp_result),
        .issue_fp   (issue_fp),
        .issue_rd   (issue_rd),
        .we3        (we3),
        .a3         (a3),
        .wd3        (wd3),
        .busy       (busy),
        .fifo_cnt   (fifo_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        int_we     = 1'b0;
        int_rd     = 5'd0;
        int_result = 32'd0;
        fp_valid   = 1'b0;
        fp_rd      = 5'd0;
        fp_result  = 32'd0;
        issue_fp   = 1'b0;
        issue_rd   = 5'd0;
    endtask

    task automatic drive_int(input logic [4:0] rd, input logic [31:0] d);
        int_we     = 1'b1;
        int_rd     = rd;
        int_result = d;
    endtask

    task automatic drive_fp(input logic [4:0] rd, input logic [31:0] d);
        fp_valid  = 1'b1;
        fp_rd     = rd;
        fp_result = d;
    endtask

    // Advance one edge and retire any write the port shows against the scoreboard.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (we3 === 1'b1) begin
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_write observed a3=%0d wd3=0x%08h expected no write", a3, wd3);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("wr_a3", {27'd0, a3}, {27'd0, e.a});
                chk("wr_wd3", wd3, e.d);
            end
        end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_we3", {31'd0, we3}, 32'd0);
        chk("rst_a3", {27'd0, a3}, 32'd0);
        chk("rst_wd3", wd3, 32'd0);
        chk("rst_cnt", {30'd0, fifo_cnt}, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ready", {31'd0, fp_ready}, 32'd1);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'd0, fp_ready}, 32'd1);
        chk("post_rst_we3", {31'd0, we3}, 32'd0);

        // Integer write, then one idle cycle.
        drive_int(5'd5, 32'h11);
        expect_wr(5'd5, 32'h11);
        tick();
        chk("int_we3", {31'd0, we3}, 32'd1);
        idle();
        tick();
        chk("idle_we3", {31'd0, we3}, 32'd0);
        chk("idle_a3_hold", {27'd0, a3}, 32'd5);
        chk("idle_wd3_hold", wd3, 32'h11);

        // FP bypass on an idle port.
        drive_fp(5'd7, 32'h3F80_0000);
        expect_wr(5'd7, 32'h3F80_0000);
        tick();
        chk("byp_we3", {31'd0, we3}, 32'd1);
        chk("byp_cnt", {30'd0, fifo_cnt}, 32'd0);
        idle();
        tick();

        // Integer stream for three cycles while FP results 8, 9, 10 arrive.
        drive_int(5'd1, 32'hA1);
        drive_fp(5'd8, 32'h88);
        expect_wr(5'd1, 32'hA1);
        tick();
        chk("q_cnt1", {30'd0, fifo_cnt}, 32'd1);
        chk("q_ready1", {31'd0, fp_ready}, 32'd1);
        drive_int(5'd2, 32'hA2);
        drive_fp(5'd9, 32'h99);
        expect_wr(5'd2, 32'hA2);
        tick();
        chk("q_cnt2", {30'd0, fifo_cnt}, 32'd2);
        chk("q_ready2", {31'd0, fp_ready}, 32'd0);
        drive_int(5'd3, 32'hA3);
        drive_fp(5'd10, 32'h1010);
        expect_wr(5'd3, 32'hA3);
        tick();
        chk("q_stall_cnt", {30'd0, fifo_cnt}, 32'd2);
        int_we = 1'b0;
        expect_wr(5'd8, 32'h88);
        tick();
        chk("q_pop8_cnt", {30'd0, fifo_cnt}, 32'd1);
        expect_wr(5'd9, 32'h99);
        tick();
        chk("q_pushpop_cnt", {30'd0, fifo_cnt}, 32'd1);
        idle();
        expect_wr(5'd10, 32'h1010);
        tick();
        chk("q_drain_cnt", {30'd0, fifo_cnt}, 32'd0);
        tick();
        chk("q_idle_we3", {31'd0, we3}, 32'd0);

        // int_rd == 0 frees the port; fp_rd == 0 is swallowed.
        drive_int(5'd0, 32'hDEAD);
        drive_fp(5'd4, 32'h44);
        expect_wr(5'd4, 32'h44);
        tick();
        chk("rd0_int_cnt", {30'd0, fifo_cnt}, 32'd0);
        idle();
        drive_fp(5'd0, 32'hBAD);
        tick();
        chk("rd0_fp_we3", {31'd0, we3}, 32'd0);
        chk("rd0_fp_cnt", {30'd0, fifo_cnt}, 32'd0);
        idle();
        drive_int(5'd6, 32'h66);
        drive_fp(5'd0, 32'hBAD);
        expect_wr(5'd6, 32'h66);
        tick();
        chk("rd0_fp_busy_port_cnt", {30'd0, fifo_cnt}, 32'd0);
        idle();
        tick();

        // Busy tracking on register 12.
        issue_fp = 1'b1;
        issue_rd = 5'd12;
        tick();
        chk("busy_set", busy, BUSY12);
        idle();
        tick();
        chk("busy_hold", busy, BUSY12);
        issue_fp = 1'b1;
        issue_rd = 5'd12;
        drive_fp(5'd12, 32'hC0C0);
        expect_wr(5'd12, 32'hC0C0);
        tick();
        chk("busy_set_wins", busy, BUSY12);
        idle();
        drive_fp(5'd12, 32'hC1C1);
        expect_wr(5'd12, 32'hC1C1);
        tick();
        chk("busy_clear", busy, 32'd0);
        idle();
        issue_fp = 1'b1;
        issue_rd = 5'd0;
        tick();
        chk("busy_rd0", busy, 32'd0);
        idle();

        // Fill the FIFO, then reset mid-cycle.
        drive_int(5'd1, 32'hB1);
        drive_fp(5'd20, 32'h2020);
        issue_fp = 1'b1;
        issue_rd = 5'd20;
        expect_wr(5'd1, 32'hB1);
        tick();
        issue_fp = 1'b0;
        drive_int(5'd2, 32'hB2);
        drive_fp(5'd21, 32'h2121);
        expect_wr(5'd2, 32'hB2);
        tick();
        chk("pre_rst_cnt", {30'd0, fifo_cnt}, 32'd2);
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we3", {31'd0, we3}, 32'd0);
        chk("mid_rst_a3", {27'd0, a3}, 32'd0);
        chk("mid_rst_cnt", {30'd0, fifo_cnt}, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_ready", {31'd0, fp_ready}, 32'd1);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("post_rst_no_write", {31'd0, we3}, 32'd0);
        chk("post_rst_cnt", {30'd0, fifo_cnt}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
